// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
// Instruction-memory read bus between the fetch stage and the instruction
// memory. The read is asynchronous: the memory returns im_rdata for im_addr
// within the same cycle.
//
// Signals
//   im_addr   word index into instruction memory (driven by fetch)
//   im_rdata  combinational read data for im_addr (driven by memory)
//
// Modports
//   master  fetch side  (drives im_addr, receives im_rdata)
//   slave   memory side (receives im_addr, drives im_rdata)
// -----------------------------------------------------------------------------
interface fetch_stage_if #(
  parameter int AW = 12
);
  logic [AW-1:0] im_addr;
  logic [31:0]   im_rdata;

  modport master (output im_addr, input im_rdata);
  modport slave  (input im_addr, output im_rdata);
endinterface

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage plus IF/ID pipeline register of a five-stage MIPS
// core. Owns the program counter, addresses instruction memory and latches
// the fetched word and its PC into the D-stage register. Delayed-branch
// model: a redirect from D never squashes the delay-slot word already in F.
//
// Ports
//   clk            system clock, rising edge
//   reset          synchronous active-high reset, highest priority
//   imem           instruction-memory bus (master side)
//   stall_i        freeze PC and IF/ID register
//   flush_i        insert a nop into IF/ID instead of the fetched word
//   redirect_i     load redirect_pc_i into the PC (branch / jal / jr)
//   redirect_pc_i  redirect target
//   f_pc_o         current F-stage PC
//   d_instr_o      IF/ID instruction
//   d_pc_o         IF/ID PC of d_instr_o
//   d_valid_o      IF/ID holds a real fetched instruction
//   pc_fault_o     sticky: an illegal PC was fetched since reset
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int          IM_DEPTH = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_stage_if.master        imem,
  input  logic                 stall_i,
  input  logic                 flush_i,
  input  logic                 redirect_i,
  input  logic [31:0]          redirect_pc_i,
  output logic [31:0]          f_pc_o,
  output logic [31:0]          d_instr_o,
  output logic [31:0]          d_pc_o,
  output logic                 d_valid_o,
  output logic                 pc_fault_o
);

  localparam int AW = $clog2(IM_DEPTH);

  // One past the last legal byte address; 33 bits so a memory that ends
  // exactly at 2^32 does not wrap the bound to zero.
  localparam logic [32:0] IM_END = {1'b0, IM_BASE} + (33'(IM_DEPTH) << 2);

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic [31:0] f_pc_q,    f_pc_d;
  logic [31:0] d_instr_q, d_instr_d;
  logic [31:0] d_pc_q,    d_pc_d;
  logic        d_valid_q, d_valid_d;
  logic        pc_fault_q, pc_fault_d;

  logic        pc_legal;
  logic [31:0] fetch_word;
  logic [31:0] next_pc;

  // Word index relative to the memory base; out-of-range PCs simply alias,
  // their data is replaced by a nop below.
  assign imem.im_addr = AW'((f_pc_q - IM_BASE) >> 2);

  assign pc_legal   = (f_pc_q[1:0] == 2'b00) &&
                      (f_pc_q >= IM_BASE) &&
                      ({1'b0, f_pc_q} < IM_END);
  assign fetch_word = pc_legal ? imem.im_rdata : NOP;
  assign next_pc    = redirect_i ? redirect_pc_i : (f_pc_q + 32'd4);

  always_comb begin
    f_pc_d     = f_pc_q;
    d_instr_d  = d_instr_q;
    d_pc_d     = d_pc_q;
    d_valid_d  = d_valid_q;
    pc_fault_d = pc_fault_q;
    if (!stall_i) begin
      // The word in F (delay slot on a redirect) always moves into IF/ID;
      // flush only turns it into a nop, the PC still advances.
      f_pc_d    = next_pc;
      d_pc_d    = f_pc_q;
      d_instr_d = flush_i ? NOP : fetch_word;
      d_valid_d = !flush_i;
      if (!pc_legal) begin
        pc_fault_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f_pc_q     <= PC_RESET;
      d_instr_q  <= NOP;
      d_pc_q     <= 32'h0000_0000;
      d_valid_q  <= 1'b0;
      pc_fault_q <= 1'b0;
    end else begin
      f_pc_q     <= f_pc_d;
      d_instr_q  <= d_instr_d;
      d_pc_q     <= d_pc_d;
      d_valid_q  <= d_valid_d;
      pc_fault_q <= pc_fault_d;
    end
  end

  assign f_pc_o     = f_pc_q;
  assign d_instr_o  = d_instr_q;
  assign d_pc_o     = d_pc_q;
  assign d_valid_o  = d_valid_q;
  assign pc_fault_o = pc_fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Table-driven bench for fetch_stage. Instruction memory word k holds
// 0x1000_0000 + k. Each step drives inputs, pushes the expected post-edge
// state to a scoreboard queue, clocks, then pops and compares.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] exp_f_pc;
    logic [31:0] exp_d_pc;
    logic [31:0] exp_d_instr;
    logic        exp_d_valid;
    logic        exp_fault;
  } step_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] f_pc, d_instr, d_pc;
  logic        d_valid, pc_fault;

  int tests_run = 0;
  int tests_failed = 0;

  step_t scoreboard[$];
  step_t table_v[20];

  fetch_stage_if #(.AW(12)) imem ();

  assign imem.im_rdata = 32'h1000_0000 + {20'd0, imem.im_addr};

  fetch_stage #(
    .PC_RESET (32'h0000_3000),
    .IM_BASE  (32'h0000_3000),
    .IM_DEPTH (4096)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem          (imem),
    .stall_i       (stall),
    .flush_i       (flush),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .f_pc_o        (f_pc),
    .d_instr_o     (d_instr),
    .d_pc_o        (d_pc),
    .d_valid_o     (d_valid),
    .pc_fault_o    (pc_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic step_t mk(input logic rst, input logic st, input logic fl,
                               input logic rd, input logic [31:0] rpc,
                               input logic [31:0] ef, input logic [31:0] edp,
                               input logic [31:0] edi, input logic ev, input logic eflt);
    step_t s;
    s.rst = rst; s.stall = st; s.flush = fl; s.redirect = rd; s.redirect_pc = rpc;
    s.exp_f_pc = ef; s.exp_d_pc = edp; s.exp_d_instr = edi;
    s.exp_d_valid = ev; s.exp_fault = eflt;
    return s;
  endfunction

  task automatic apply(input string tag, input step_t s);
    step_t e;
    logic [11:0] exp_addr;
    reset = s.rst; stall = s.stall; flush = s.flush;
    redirect = s.redirect; redirect_pc = s.redirect_pc;
    scoreboard.push_back(s);
    @(posedge clk);
    #1;
    e = scoreboard.pop_front();
    exp_addr = 12'((e.exp_f_pc - 32'h0000_3000) >> 2);
    check({tag, " f_pc"},    f_pc,    e.exp_f_pc);
    check({tag, " d_pc"},    d_pc,    e.exp_d_pc);
    check({tag, " d_instr"}, d_instr, e.exp_d_instr);
    check({tag, " d_valid"}, {31'd0, d_valid},  {31'd0, e.exp_d_valid});
    check({tag, " pc_fault"},{31'd0, pc_fault}, {31'd0, e.exp_fault});
    check({tag, " im_addr"}, {20'd0, imem.im_addr}, {20'd0, exp_addr});
    $display("[TB] %s rst=%0b st=%0b fl=%0b rd=%0b rpc=%08h -> f_pc=%08h d_pc=%08h d_instr=%08h v=%0b flt=%0b",
             tag, s.rst, s.stall, s.flush, s.redirect, s.redirect_pc,
             f_pc, d_pc, d_instr, d_valid, pc_fault);
  endtask

  initial begin
    //                  rst st fl rd target         f_pc           d_pc           d_instr        v  flt
    table_v[0]  = mk(0, 0, 0, 0, 32'h0,         32'h0000_3004, 32'h0000_3000, 32'h1000_0000, 1, 0);
    table_v[1]  = mk(0, 0, 0, 0, 32'h0,         32'h0000_3008, 32'h0000_3004, 32'h1000_0001, 1, 0);
    table_v[2]  = mk(0, 0, 0, 1, 32'h0000_3040, 32'h0000_3040, 32'h0000_3008, 32'h1000_0002, 1, 0);
    table_v[3]  = mk(0, 0, 0, 0, 32'h0,         32'h0000_3044, 32'h0000_3040, 32'h1000_0010, 1, 0);
    table_v[4]  = mk(0, 1, 0, 0, 32'h0,         32'h0000_3044, 32'h0000_3040, 32'h1000_0010, 1, 0);
    table_v[5]  = mk(0, 1, 0, 1, 32'h0000_3100, 32'h0000_3044, 32'h0000_3040, 32'h1000_0010, 1, 0);
    table_v[6]  = mk(0, 1, 1, 0, 32'h0,         32'h0000_3044, 32'h0000_3040, 32'h1000_0010, 1, 0);
    table_v[7]  = mk(0, 0, 0, 0, 32'h0,         32'h0000_3048, 32'h0000_3044, 32'h1000_0011, 1, 0);
    table_v[8]  = mk(0, 0, 0, 1, 32'h0000_3010, 32'h0000_3010, 32'h0000_3048, 32'h1000_0012, 1, 0);
    table_v[9]  = mk(0, 0, 1, 1, 32'h0000_3100, 32'h0000_3100, 32'h0000_3010, 32'h0000_0000, 0, 0);
    table_v[10] = mk(0, 0, 0, 0, 32'h0,         32'h0000_3104, 32'h0000_3100, 32'h1000_0040, 1, 0);
    table_v[11] = mk(0, 0, 1, 0, 32'h0,         32'h0000_3108, 32'h0000_3104, 32'h0000_0000, 0, 0);
    table_v[12] = mk(0, 0, 0, 1, 32'h0000_3002, 32'h0000_3002, 32'h0000_3108, 32'h1000_0042, 1, 0);
    table_v[13] = mk(0, 0, 0, 0, 32'h0,         32'h0000_3006, 32'h0000_3002, 32'h0000_0000, 1, 1);
    table_v[14] = mk(0, 0, 0, 1, 32'h0000_6ffc, 32'h0000_6ffc, 32'h0000_3006, 32'h0000_0000, 1, 1);
    table_v[15] = mk(0, 0, 0, 1, 32'h0000_7000, 32'h0000_7000, 32'h0000_6ffc, 32'h1000_0fff, 1, 1);
    table_v[16] = mk(0, 0, 0, 0, 32'h0,         32'h0000_7004, 32'h0000_7000, 32'h0000_0000, 1, 1);
    table_v[17] = mk(0, 0, 0, 1, 32'h0000_2ffc, 32'h0000_2ffc, 32'h0000_7004, 32'h0000_0000, 1, 1);
    table_v[18] = mk(0, 0, 0, 0, 32'h0,         32'h0000_3000, 32'h0000_2ffc, 32'h0000_0000, 1, 1);
    table_v[19] = mk(0, 0, 0, 0, 32'h0,         32'h0000_3004, 32'h0000_3000, 32'h1000_0000, 1, 1);

    reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset f_pc",     f_pc,     32'h0000_3000);
    check("reset d_pc",     d_pc,     32'h0000_0000);
    check("reset d_instr",  d_instr,  32'h0000_0000);
    check("reset d_valid",  {31'd0, d_valid},  32'd0);
    check("reset pc_fault", {31'd0, pc_fault}, 32'd0);
    $display("[TB] reset f_pc=%08h d_valid=%0b pc_fault=%0b", f_pc, d_valid, pc_fault);

    for (int i = 0; i < 20; i++) begin
      apply($sformatf("row%0d", i), table_v[i]);
    end

    // PC wraps modulo 2^32 past the top of the address space.
    apply("wrap_redir", mk(0, 0, 0, 1, 32'hffff_fffc, 32'hffff_fffc, 32'h0000_3004, 32'h1000_0001, 1, 1));
    apply("wrap_inc",   mk(0, 0, 0, 0, 32'h0,         32'h0000_0000, 32'hffff_fffc, 32'h0000_0000, 1, 1));
    apply("to_3020",    mk(0, 0, 0, 1, 32'h0000_3020, 32'h0000_3020, 32'h0000_0000, 32'h0000_0000, 1, 1));

    // Reset arriving in the middle of a stall (with a redirect pending) wins.
    apply("stall_hold", mk(0, 1, 0, 0, 32'h0,         32'h0000_3020, 32'h0000_0000, 32'h0000_0000, 1, 1));
    apply("stall_rst",  mk(1, 1, 1, 1, 32'h0000_3100, 32'h0000_3000, 32'h0000_0000, 32'h0000_0000, 0, 0));
    apply("post_rst",   mk(0, 0, 0, 0, 32'h0,         32'h0000_3004, 32'h0000_3000, 32'h1000_0000, 1, 0));

    if (scoreboard.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL scoreboard: %0d entries left, expected 0", scoreboard.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the five-stage MIPS core. It owns the program counter, drives the instruction-memory read address and latches the fetched word plus its PC into the D-stage register. The D-stage instruction decoder and the control logic read that register directly. It follows the delayed-branch model: a redirect issued from D never squashes the delay-slot instruction already in F.

## Interface
- PC_RESET, 32'h0000_3000, PC value loaded on reset
- IM_BASE, 32'h0000_3000, byte address of instruction-memory word 0
- IM_DEPTH, 4096, instruction-memory size in 32-bit words (power of two)

- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; has priority over every other input
- stall  in  1  from hazard unit; freezes PC and IF/ID register
- flush  in  1  replaces the word entering IF/ID with a nop
- redirect  in  1  D-stage branch taken / jal / jr; load redirect_pc into PC
- redirect_pc  in  32  target PC, valid when redirect=1
- im_addr  out  log2(IM_DEPTH)  word index into instruction memory
- im_rdata  in  32  combinational read data for im_addr
- f_pc  out  32  current PC (F stage)
- d_instr  out  32  IF/ID instruction, feeds decoder op/funct fields
- d_pc  out  32  IF/ID PC of d_instr
- d_valid  out  1  IF/ID holds a real fetched instruction
- pc_fault  out  1  sticky: an illegal PC was fetched since reset

## Operation
- f_pc is a register. im_addr = (f_pc - IM_BASE) >> 2, truncated to log2(IM_DEPTH) bits.
- A PC is legal when f_pc[1:0]==0 and IM_BASE <= f_pc < IM_BASE + 4*IM_DEPTH. Compare as 32-bit unsigned.
- Fetched word = im_rdata if the PC is legal, else 32'h0000_0000 (sll nop).
- Next PC when not stalled: redirect ? redirect_pc : f_pc + 4. Addition wraps modulo 2^32.
- Priority on each rising edge: reset > stall > {flush, redirect}. Flush and redirect are independent and may coincide.
- reset: f_pc=PC_RESET, d_instr=0, d_pc=0, d_valid=0, pc_fault=0.
- stall=1: f_pc, d_instr, d_pc and d_valid hold. flush and redirect are ignored; the hazard unit re-asserts redirect once the stall drops.
- stall=0, flush=0: d_instr=fetched word, d_pc=f_pc, d_valid=1, and f_pc advances to the next PC.
- stall=0, flush=1: d_instr=0, d_pc=f_pc, d_valid=0. The PC still advances, using redirect if it is asserted.
- pc_fault sets on any non-stalled edge that fetches an illegal PC. It stays set until reset. An illegal PC does not stop fetch.
- Delay slot: when redirect arrives, the instruction at branch_pc+4 is in F. It enters IF/ID on the same edge that loads redirect_pc into f_pc.

## Timing
- Fetch latency is one cycle. The word at PC X appears on d_instr in the cycle after f_pc==X, provided there is no stall.
- im_addr is combinational from f_pc; im_rdata must settle in the same cycle.
- Redirect-to-target: redirect asserted in cycle n gives f_pc=redirect_pc in n+1 and the target on d_instr in n+2.
- All outputs are register outputs except im_addr.
- Reset in the middle of a stall or redirect: reset wins and the PC returns to PC_RESET on that edge.

## Test plan
- Reset then free-run, memory word k = 0x1000_0000+k → cycle 1 after reset: d_pc=0x3000, d_instr=0x1000_0000, d_valid=1. Cycle 2: d_pc=0x3004, d_instr=0x1000_0001.
- stall held 3 cycles with f_pc=0x3008 → f_pc, d_instr and d_pc unchanged for those 3 cycles. After release, d_pc=0x3008 on the next edge.
- redirect=1, redirect_pc=0x3040 while d_pc=0x3004 (beq) and f_pc=0x3008 → next edge: d_pc=0x3008 (delay slot kept), f_pc=0x3040. Edge after that: d_pc=0x3040.
- flush=1 and redirect=1 at f_pc=0x3010, target 0x3100 → d_instr=0, d_valid=0, f_pc=0x3100. stall=1 together with redirect → PC holds at 0x3010.
- redirect_pc=0x3002 (misaligned) → next fetch yields d_instr=0 and pc_fault=1, and f_pc continues at 0x3006. redirect_pc=0x7000 with IM_DEPTH=4096 (0x7000 is the first out-of-range address) → d_instr=0 and pc_fault stays 1 until reset.
- Reset asserted during an active stall with f_pc=0x3020 → next edge: f_pc=0x3000, d_valid=0, pc_fault=0.
